// File: rtl/tetris_board.sv
// tetris_board: 12x10 board that ORs four-cell pieces in, clears full rows; ports Clk/Reset, lock_req + cell_r*/cell_c* in; busy, done, lines_cleared, game_over, arr0..arr11 out
module tetris_board (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       lock_req,
  input  logic [3:0] cell_r0,
  input  logic [3:0] cell_r1,
  input  logic [3:0] cell_r2,
  input  logic [3:0] cell_r3,
  input  logic [3:0] cell_c0,
  input  logic [3:0] cell_c1,
  input  logic [3:0] cell_c2,
  input  logic [3:0] cell_c3,
  output logic       busy,
  output logic       done,
  output logic [7:0] lines_cleared,
  output logic       game_over,
  output logic [9:0] arr0,
  output logic [9:0] arr1,
  output logic [9:0] arr2,
  output logic [9:0] arr3,
  output logic [9:0] arr4,
  output logic [9:0] arr5,
  output logic [9:0] arr6,
  output logic [9:0] arr7,
  output logic [9:0] arr8,
  output logic [9:0] arr9,
  output logic [9:0] arr10,
  output logic [9:0] arr11
);
  typedef enum logic [1:0] {IDLE, WRITE, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [9:0] b [12];
  logic [9:0] wm [12];
  logic [3:0] r;
  logic [3:0] cr [4];
  logic [3:0] cc [4];
  logic accept, full;
  assign accept = state == IDLE && lock_req && !game_over;
  assign full = b[r] == 10'h3FF;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign {arr11, arr10, arr9, arr8, arr7, arr6, arr5, arr4, arr3, arr2, arr1, arr0} =
         {b[11], b[10], b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1], b[0]};
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? WRITE : IDLE;
      WRITE:   nxt = SCAN;
      SCAN:    nxt = (!full && r == 4'd0) ? DONE : SCAN;
      default: nxt = IDLE;
    endcase
  end
  // per-row mask of the registered cells; off-board cells contribute nothing
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      wm[i] = '0;
      for (int j = 0; j < 4; j++)
        wm[i] = wm[i] | ((cr[j] == 4'(i) && cc[j] < 4'd10) ? (10'd1 << cc[j]) : 10'd0);
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 12; i++) b[i] <= '0;
      for (int j = 0; j < 4; j++) begin
        cr[j] <= '0;
        cc[j] <= '0;
      end
      lines_cleared <= '0;
      game_over <= 1'b0;
      r <= 4'd11;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cr[0] <= cell_r0;
          cr[1] <= cell_r1;
          cr[2] <= cell_r2;
          cr[3] <= cell_r3;
          cc[0] <= cell_c0;
          cc[1] <= cell_c1;
          cc[2] <= cell_c2;
          cc[3] <= cell_c3;
        end
        WRITE: begin
          for (int i = 0; i < 12; i++) b[i] <= b[i] | wm[i];
          r <= 4'd11;
        end
        // a full row collapses everything above it down by one and keeps r so the new row is re-examined
        SCAN: if (full) begin
          for (int i = 1; i < 12; i++) if (4'(i) <= r) b[i] <= b[i-1];
          b[0] <= '0;
          lines_cleared <= lines_cleared + 8'd1;
        end else if (r != 4'd0) r <= r - 4'd1;
        default: begin
          if (|b[0]) game_over <= 1'b1;
          r <= 4'd11;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tetris_board.sv
// tb_tetris_board: directed and random piece locks checked against a row-compaction board model
module tb_tetris_board;
  logic Clk = 0, Reset = 0, lock_req = 0;
  logic [3:0] cell_r0 = 0, cell_r1 = 0, cell_r2 = 0, cell_r3 = 0;
  logic [3:0] cell_c0 = 0, cell_c1 = 0, cell_c2 = 0, cell_c3 = 0;
  logic busy, done, game_over;
  logic [7:0] lines_cleared;
  logic [9:0] arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
  int n_chk = 0, n_err = 0;
  logic [9:0] m [12];
  logic [7:0] m_lines;
  logic m_go;

  tetris_board dut (
    .Clk(Clk), .Reset(Reset), .lock_req(lock_req),
    .cell_r0(cell_r0), .cell_r1(cell_r1), .cell_r2(cell_r2), .cell_r3(cell_r3),
    .cell_c0(cell_c0), .cell_c1(cell_c1), .cell_c2(cell_c2), .cell_c3(cell_c3),
    .busy(busy), .done(done), .lines_cleared(lines_cleared), .game_over(game_over),
    .arr0(arr0), .arr1(arr1), .arr2(arr2), .arr3(arr3), .arr4(arr4), .arr5(arr5),
    .arr6(arr6), .arr7(arr7), .arr8(arr8), .arr9(arr9), .arr10(arr10), .arr11(arr11)
  );

  always #5 Clk = ~Clk;

  function automatic logic [119:0] dut_board();
    return {arr11, arr10, arr9, arr8, arr7, arr6, arr5, arr4, arr3, arr2, arr1, arr0};
  endfunction

  function automatic logic [119:0] model_board();
    logic [119:0] v;
    for (int i = 0; i < 12; i++) v[i*10 +: 10] = m[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    lock_req = 1;
    cell_r0 = 11; cell_c0 = 0;
    @(posedge Clk);
    #1 Reset = 0;
    lock_req = 0;
    for (int i = 0; i < 12; i++) m[i] = '0;
    m_lines = 0;
    m_go = 0;
  endtask

  // model: OR the piece in, drop every full row and pack the rest to the bottom
  task automatic model_lock(input int rr[4], input int cc[4], output int k);
    logic [9:0] t [12];
    int idx;
    k = 0;
    for (int j = 0; j < 4; j++)
      if (rr[j] < 12 && cc[j] < 10) m[rr[j]][cc[j]] = 1'b1;
    for (int i = 0; i < 12; i++) t[i] = '0;
    idx = 11;
    for (int i = 11; i >= 0; i--)
      if (m[i] == 10'h3FF) k++;
      else begin
        t[idx] = m[i];
        idx--;
      end
    for (int i = 0; i < 12; i++) m[i] = t[i];
    m_lines = m_lines + 8'(k);
    if (m[0] != 0) m_go = 1;
  endtask

  task automatic op(input int a0, b0, a1, b1, a2, b2, a3, b3);
    int rr[4], cc[4];
    int k, busy_cnt, done_cnt, done_at, exp_busy;
    bit rejected;
    rr = '{a0, a1, a2, a3};
    cc = '{b0, b1, b2, b3};
    rejected = m_go;
    k = 0;
    if (!rejected) model_lock(rr, cc, k);
    exp_busy = rejected ? 0 : 14 + k;
    @(negedge Clk);
    cell_r0 = 4'(a0); cell_c0 = 4'(b0);
    cell_r1 = 4'(a1); cell_c1 = 4'(b1);
    cell_r2 = 4'(a2); cell_c2 = 4'(b2);
    cell_r3 = 4'(a3); cell_c3 = 4'(b3);
    lock_req = 1;
    @(posedge Clk);
    #1 lock_req = 0;
    {cell_r0, cell_r1, cell_r2, cell_r3, cell_c0, cell_c1, cell_c2, cell_c3} = 32'($urandom);
    busy_cnt = 0;
    done_cnt = 0;
    done_at = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge Clk);
      if (!busy) break;
      busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      lock_req = (cyc >= 2 && cyc <= 6);
    end
    lock_req = 0;
    chk("busy_cycles", 128'(busy_cnt), 128'(exp_busy));
    chk("done_count", 128'(done_cnt), 128'(rejected ? 0 : 1));
    chk("done_cycle", 128'(done_at), 128'(exp_busy));
    chk("board", 128'(dut_board()), 128'(model_board()));
    chk("lines", 128'(lines_cleared), 128'(m_lines));
    chk("game_over", 128'(game_over), 128'(m_go));
  endtask

  initial begin
    int rr[4], cc[4];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("reset_board", 128'(dut_board()), 128'(0));
      chk("reset_ctrl", 128'({busy, done, lines_cleared, game_over}), 128'(0));
    end
    op(11, 0, 11, 1, 11, 2, 11, 3);
    op(11, 4, 11, 5, 11, 6, 11, 7);
    op(11, 8, 11, 9, 10, 8, 10, 9);
    chk("arr11_after_clear", 128'(arr11), 128'(10'h300));
    op(12, 3, 5, 10, 11, 0, 11, 0);

    do_reset();
    op(11, 4, 11, 5, 11, 6, 11, 7);
    op(11, 8, 11, 9, 10, 8, 10, 9);
    op(10, 4, 10, 5, 10, 6, 10, 7);
    op(9, 0, 9, 0, 9, 0, 9, 0);
    op(10, 0, 10, 1, 10, 2, 10, 3);
    op(11, 0, 11, 1, 11, 2, 11, 3);

    do_reset();
    op(11, 2, 11, 3, 11, 4, 11, 5);
    op(11, 6, 11, 7, 11, 8, 11, 9);
    op(10, 2, 10, 3, 10, 4, 10, 5);
    op(10, 6, 10, 7, 10, 8, 10, 9);
    op(9, 0, 9, 0, 9, 0, 9, 0);
    op(10, 0, 10, 1, 11, 0, 11, 1);
    chk("row9_landed", 128'(arr11), 128'(10'h001));
    chk("two_clears", 128'(lines_cleared), 128'(2));

    do_reset();
    op(0, 4, 12, 0, 12, 0, 12, 0);
    op(11, 0, 11, 1, 11, 2, 11, 3);

    do_reset();
    @(negedge Clk);
    cell_r0 = 11; cell_c0 = 0; cell_r1 = 11; cell_c1 = 1;
    cell_r2 = 11; cell_c2 = 2; cell_r3 = 11; cell_c3 = 3;
    lock_req = 1;
    @(posedge Clk);
    #1 lock_req = 0;
    repeat (5) @(negedge Clk);
    Reset = 1;
    @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    chk("mid_scan_reset_board", 128'(dut_board()), 128'(0));
    chk("mid_scan_reset_busy", 128'(busy), 128'(0));
    begin
      int dn = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) dn++;
        @(negedge Clk);
      end
      chk("mid_scan_no_done", 128'(dn), 128'(0));
    end
    for (int i = 0; i < 12; i++) m[i] = '0;
    m_lines = 0;
    m_go = 0;

    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < 4; j++) begin
        rr[j] = $urandom_range(8, 12);
        cc[j] = $urandom_range(0, 10);
      end
      op(rr[0], cc[0], rr[1], cc[1], rr[2], cc[2], rr[3], cc[3]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tetris_board.md
TETRIS_BOARD -- requirements
Module: tetris_board

Interface
REQ-001 SHALL provide the following ports, where the clock is Clk and the reset is Reset (one clock; reset synchronous, active-high):
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- lock_req  in  1  request to lock one piece (four cells) into the board.
- cell_r0..cell_r3  in  4 each  row index of each piece cell; 0 = top row.
- cell_c0..cell_c3  in  4 each  column index of each piece cell; 0 = bit 0.
- busy  out  1  high while a lock or line-clear operation is in progress.
- done  out  1  one-cycle pulse at the end of each operation.
- lines_cleared  out  8  running count of cleared rows.
- game_over  out  1  sticky flag.
- arr0..arr11  out  10 each  board rows, arr0 at the top; bit c = column c; 1 = occupied.

Function
REQ-002 SHALL hold the board as 12 rows x 10 bits and drive arr0..arr11 directly from registers, with no combinational path from inputs.
REQ-003 SHALL use the FSM states IDLE, WRITE, SCAN and DONE.
REQ-004 SHALL, in IDLE, accept a request when lock_req=1, busy=0 and game_over=0 at a rising edge; the next state is WRITE.
REQ-005 SHALL register cell_r0..3 and cell_c0..3 on acceptance; input changes after acceptance have no effect.
REQ-006 SHALL ignore lock_req in any state other than IDLE, and while game_over=1; the request is not queued.
REQ-007 SHALL, in WRITE (1 cycle), OR each registered cell into the board; overlapping, duplicate or already-occupied cells are OR-ed with no error.
REQ-008 SHALL ignore any cell with row >11 or column >9, leaving the board unchanged for that cell.
REQ-009 SHALL set the scan pointer r to 11 and move to SCAN on leaving WRITE.
REQ-010 SHALL, in SCAN, examine row r each cycle:
- if row r = 10'h3FF: in one cycle, rows r..1 take the values of rows r-1..0, row 0 becomes 0, lines_cleared increments, and r is unchanged so the shifted-in row is re-examined;
- else if r = 0: next state is DONE;
- else r decrements.
REQ-011 SHALL make lines_cleared wrap from 255 to 0.
REQ-012 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-013 SHALL, in DONE, set game_over if row 0 is nonzero; game_over stays set until Reset.
REQ-014 SHALL drive busy=1 in WRITE, SCAN and DONE, and busy=0 in IDLE.
REQ-015 SHALL give exact timing for an operation that clears k rows:
- request accepted at edge T;
- busy=1 from T+1;
- done=1 in cycle T+14+k;
- busy=0 from T+15+k.
REQ-016 SHALL allow a new request to be accepted on the first IDLE cycle after DONE.
REQ-017 SHALL keep arr outputs stable in IDLE.
REQ-018 SHALL change arr outputs only at WRITE edges and clear-shift edges.

Reset
REQ-019 SHALL, when Reset=1 at a rising edge, clear all board rows, lines_cleared, game_over, done and busy to 0, and place the FSM in IDLE with the scan pointer at 11.
REQ-020 SHALL give Reset priority over every other event, including assertion mid-WRITE or mid-SCAN; the partial operation is discarded with no done pulse.
REQ-021 SHALL treat a lock_req coincident with Reset as ignored.

Verification
REQ-022 SHALL be verified by directed scenarios covering at least the following:
- Reset, then idle 5 cycles -> arr0..arr11=0, busy=0, done=0, lines_cleared=0, game_over=0.
- Lock cells (11,0)(11,1)(11,2)(11,3) -> arr11=10'h00F, other rows 0, busy high 14 cycles, done pulses once, lines_cleared=0.
- Lock row 11 cols 0-3, then 4-7, then (11,8)(11,9)(10,8)(10,9) -> third operation busy 15 cycles; arr11=10'h300, arr10=0, lines_cleared=1.
- Preload rows 10 and 11 to 10'h3F0 and row 9 to 10'h001 via locks, then lock (10,0..3) and (11,0..3) in two ops, so the second fills row 11 only -> row 11 cleared; repeat with a piece filling both rows 10 and 11 -> lines_cleared increments by 2, the row-9 contents land in arr11, and busy lasts 16 cycles.
- Lock a cell at (0,4) -> game_over=1 in the cycle after done; a later lock_req is not accepted (busy stays 0, board unchanged).
- Assert lock_req while busy -> ignored, no extra done. Cell (12,3) or (5,10) -> board unchanged for that cell. Reset asserted during SCAN -> next cycle all arr=0, busy=0, no done pulse.
